// File: rtl/hazard_scoreboard.sv
// EX-stage operand forwarding, load-use detection and a per-register long-latency scoreboard.
// Optional `HAZARD_STATS_EN adds the stall_cycles and waw_stalls saturating counters.
module hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*5-1:0]    ex_rs,
  input  logic [FWD_STAGES-1:0]   stage_reg_write,
  input  logic [FWD_STAGES*5-1:0] stage_rd,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  input  logic [NUM_SRC*5-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic                    ex_mem_read,
  input  logic [4:0]              ex_rd,
  input  logic                    issue_valid,
  input  logic                    issue_long,
  input  logic [4:0]              issue_rd,
  input  logic [LAT_W-1:0]        issue_lat,
  output logic                    stall,
  output logic [31:0]             pend_vec
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             waw_stalls
`endif
);

  logic [LAT_W-1:0] pend_cnt [32];
  logic             load_use;
  logic             raw_long;
  logic             waw_long;
  logic             accept;
  logic [LAT_W-1:0] lat_eff;

  // Stages are scanned oldest-first so the youngest matching stage wins.
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (stage_reg_write[k] && stage_rd[k*5 +: 5] != 5'd0 &&
            stage_rd[k*5 +: 5] == ex_rs[s*5 +: 5])
          fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  // A count of 1 means the result reaches WB next cycle, where forwarding covers it.
  always_comb begin
    load_use = 1'b0;
    raw_long = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used[s]) begin
        if (ex_mem_read && ex_rd != 5'd0 && id_rs[s*5 +: 5] == ex_rd)
          load_use = 1'b1;
        if (id_rs[s*5 +: 5] != 5'd0 && pend_cnt[id_rs[s*5 +: 5]] > LAT_W'(1))
          raw_long = 1'b1;
      end
    end
    waw_long = issue_valid && issue_rd != 5'd0 && pend_cnt[issue_rd] != '0;
    stall    = load_use || raw_long || waw_long;
  end

  assign accept  = issue_valid && issue_long && issue_rd != 5'd0 && !stall;
  assign lat_eff = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
    end else begin
      pend_cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (accept && issue_rd == 5'(r))
          pend_cnt[r] <= lat_eff;
        else if (pend_cnt[r] != '0)
          pend_cnt[r] <= pend_cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    pend_vec = '0;
    for (int r = 1; r < 32; r++) pend_vec[r] = (pend_cnt[r] != '0);
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      waw_stalls   <= '0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (waw_long && waw_stalls != 16'hFFFF)
        waw_stalls <= waw_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for forwarding/load-use plus scoreboard sequences.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ex_rs;
  logic [1:0]  stage_reg_write;
  logic [9:0]  stage_rd;
  logic [3:0]  fwd_sel;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_lat;
  logic        stall;
  logic [31:0] pend_vec;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] waw_stalls;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .stage_reg_write(stage_reg_write),
    .stage_rd(stage_rd), .fwd_sel(fwd_sel), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .issue_valid(issue_valid),
    .issue_long(issue_long), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .stall(stall), .pend_vec(pend_vec)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .waw_stalls(waw_stalls)
`endif
  );

  typedef struct {
    logic [9:0] ex_rs;
    logic [1:0] srw;
    logic [9:0] stage_rd;
    logic [9:0] id_rs;
    logic [1:0] used;
    logic       mem_read;
    logic [4:0] ex_rd;
    logic [3:0] exp_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_rs = '0; stage_reg_write = '0; stage_rd = '0; id_rs = '0; id_rs_used = '0;
    ex_mem_read = 0; ex_rd = '0; issue_valid = 0; issue_long = 0; issue_rd = '0;
    issue_lat = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    issue_valid = 1; issue_long = 1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic no_issue();
    issue_valid = 0; issue_long = 0; issue_rd = '0; issue_lat = '0;
  endtask

  initial begin
    int n;
    // ex_rs/stage_rd/id_rs packed {src1/stage1, src0/stage0}
    vecs[0]  = '{{5'd0,5'd5}, 2'b11, {5'd5,5'd5}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0001, 1'b0};
    vecs[1]  = '{{5'd0,5'd5}, 2'b10, {5'd5,5'd5}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0010, 1'b0};
    vecs[2]  = '{{5'd0,5'd0}, 2'b11, {5'd0,5'd0}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0000, 1'b0};
    vecs[3]  = '{{5'd7,5'd5}, 2'b11, {5'd7,5'd5}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b1001, 1'b0};
    vecs[4]  = '{{5'd7,5'd5}, 2'b01, {5'd7,5'd5}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0001, 1'b0};
    vecs[5]  = '{{5'd4,5'd3}, 2'b10, {5'd3,5'd3}, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0010, 1'b0};
    vecs[6]  = '{10'd0, 2'b00, 10'd0, {5'd7,5'd0}, 2'b10, 1'b1, 5'd7, 4'b0000, 1'b1};
    vecs[7]  = '{10'd0, 2'b00, 10'd0, {5'd7,5'd0}, 2'b01, 1'b1, 5'd7, 4'b0000, 1'b0};
    vecs[8]  = '{10'd0, 2'b00, 10'd0, {5'd0,5'd0}, 2'b11, 1'b1, 5'd0, 4'b0000, 1'b0};
    vecs[9]  = '{10'd0, 2'b00, 10'd0, {5'd7,5'd7}, 2'b11, 1'b0, 5'd7, 4'b0000, 1'b0};
    vecs[10] = '{10'd0, 2'b00, 10'd0, {5'd3,5'd7}, 2'b01, 1'b1, 5'd7, 4'b0000, 1'b1};

    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("reset_pend_vec", pend_vec, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_fwd_sel", {28'd0, fwd_sel}, 32'd0);

    foreach (vecs[i]) begin
      ex_rs = vecs[i].ex_rs; stage_reg_write = vecs[i].srw; stage_rd = vecs[i].stage_rd;
      id_rs = vecs[i].id_rs; id_rs_used = vecs[i].used;
      ex_mem_read = vecs[i].mem_read; ex_rd = vecs[i].ex_rd;
      #1;
      check($sformatf("vec%0d_fwd_sel", i), {28'd0, fwd_sel}, {28'd0, vecs[i].exp_fwd});
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
    end
    idle();
    tick();

    // Long RAW: x9, latency 4; stall for counts 4,3,2
    issue(5'd9, 4'd4);
    #1;
    check("raw_accept_no_stall", {31'd0, stall}, 32'd0);
    tick();
    no_issue();
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    #1;
    check("raw_pend_set", {31'd0, pend_vec[9]}, 32'd1);
    n = 0;
    for (int c = 0; c < 10 && stall; c++) begin
      n++;
      tick();
    end
    check("raw_stall_cycles", n, 3);
    check("raw_release_pend", {31'd0, pend_vec[9]}, 32'd1);
    tick();
    check("raw_pend_clear", pend_vec, 32'd0);
    idle();

    // WAW: counter at 3 must not be reloaded
    issue(5'd9, 4'd4);
    tick();
    tick();
    issue(5'd9, 4'd15);
    #1;
    check("waw_stall", {31'd0, stall}, 32'd1);
    tick();
    no_issue();
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    #1;
    check("waw_cnt2_raw_stall", {31'd0, stall}, 32'd1);
    tick();
    check("waw_no_reload", {31'd0, stall}, 32'd0);
    tick();
    check("waw_drained", pend_vec, 32'd0);
    idle();

    issue(5'd0, 4'd5);
    #1;
    check("rd0_no_stall", {31'd0, stall}, 32'd0);
    tick();
    check("rd0_no_pend", pend_vec, 32'd0);
    issue_valid = 1; issue_long = 0; issue_rd = 5'd5; issue_lat = 4'd5;
    tick();
    check("short_issue_no_pend", pend_vec, 32'd0);
    no_issue();

    // Accept suppressed while stalled by load-use
    ex_mem_read = 1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    issue(5'd6, 4'd3);
    tick();
    check("stalled_no_accept", pend_vec, 32'd0);
    idle();

    // Zero latency is treated as 1 and never RAW-stalls
    issue(5'd4, 4'd0);
    tick();
    no_issue();
    id_rs = {5'd4, 5'd0}; id_rs_used = 2'b10;
    #1;
    check("lat0_pend", pend_vec, 32'h0000_0010);
    check("lat0_no_stall", {31'd0, stall}, 32'd0);
    tick();
    check("lat0_clear", pend_vec, 32'd0);
    idle();

    // Reset mid-countdown
    issue(5'd12, 4'd12);
    tick();
    no_issue();
    tick(); tick();
    check("mid_pend_12", pend_vec, 32'h0000_1000);
    id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("mid_rst_pend", pend_vec, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    idle();

`ifdef HAZARD_STATS_EN
    rst = 1; tick(); rst = 0;
    ex_mem_read = 1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    repeat (5) tick();
    idle();
    #1;
    check("stats_stall_cycles", stall_cycles, 32'd5);
    check("stats_waw_zero", {16'd0, waw_stalls}, 32'd0);
    force dut.stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles;
    ex_mem_read = 1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    repeat (3) tick();
    check("stats_saturate", stall_cycles, 32'hFFFF_FFFF);
    idle();
    issue(5'd9, 4'd5);
    tick();
    repeat (2) tick();
    check("stats_waw_count", {16'd0, waw_stalls}, 32'd2);
    idle();
    rst = 1; tick(); rst = 0;
    #1;
    check("stats_rst", stall_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
